// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and FSM state type for the CNN argmax voter
package cnn_pkg;

  localparam int DW_DEFAULT = 24;
  localparam int NUM_CLASS  = 6;

  localparam logic [2:0] INVALID_CLASS = 3'd7;
  localparam logic [2:0] LAST_IDX      = 3'(NUM_CLASS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

endpackage

// File: rtl/cnn_argmax_vote.sv
// rtl/cnn_argmax_vote.sv - sequential argmax over six CNN scores with margin-gated stability voting
module cnn_argmax_vote
  import cnn_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int STABLE_CNT = 3
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 CNN_VALID,
  input  logic signed [DW-1:0] CNN_OUT1,
  input  logic signed [DW-1:0] CNN_OUT2,
  input  logic signed [DW-1:0] CNN_OUT3,
  input  logic signed [DW-1:0] CNN_OUT4,
  input  logic signed [DW-1:0] CNN_OUT5,
  input  logic signed [DW-1:0] CNN_OUT6,
  input  logic        [DW:0]   MARGIN_TH,
  input  logic                 CLEAR,
  output logic                 BUSY,
  output logic                 RESULT_VALID,
  output logic        [2:0]    RESULT_CLASS,
  output logic        [DW:0]   RESULT_MARGIN,
  output logic                 CONFIDENT,
  output logic                 STABLE,
  output logic                 OVERRUN
);

  localparam int                     CW       = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]          CNT_MAX  = CW'(STABLE_CNT);
  localparam logic signed [DW-1:0]   MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [DW-1:0]  r_score [NUM_CLASS];
  logic        [2:0]     r_idx;
  logic signed [DW-1:0]  r_best;
  logic signed [DW-1:0]  r_second;
  logic        [2:0]     r_best_idx;
  logic        [CW-1:0]  r_cnt;
  logic        [2:0]     r_last_class;
  logic                  r_result_valid;
  logic        [2:0]     r_result_class;
  logic        [DW:0]    r_result_margin;
  logic                  r_confident;
  logic                  r_stable;
  logic                  r_overrun;

  logic signed [DW-1:0]  w_x;
  logic        [DW:0]    w_margin;
  logic                  w_confident;
  logic        [CW-1:0]  w_cnt_nxt;
  logic        [2:0]     w_last_nxt;

  assign w_x = r_score[r_idx];
  // best >= second always holds, so the sign-extended difference is non-negative
  assign w_margin    = {r_best[DW-1], r_best} - {r_second[DW-1], r_second};
  assign w_confident = (w_margin >= MARGIN_TH);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (CNN_VALID) w_state_nxt = ST_SCAN;
      ST_SCAN:   if (r_idx == LAST_IDX) w_state_nxt = ST_DECIDE;
      ST_DECIDE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last_class;
    if (!w_confident) begin
      w_cnt_nxt = '0;
    end else if (r_best_idx == r_last_class) begin
      w_cnt_nxt = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
    end else begin
      w_cnt_nxt  = CW'(1);
      w_last_nxt = r_best_idx;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_CLASS; i++) r_score[i] <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CNN_VALID) begin
            r_score[0] <= CNN_OUT1;
            r_score[1] <= CNN_OUT2;
            r_score[2] <= CNN_OUT3;
            r_score[3] <= CNN_OUT4;
            r_score[4] <= CNN_OUT5;
            r_score[5] <= CNN_OUT6;
            r_best     <= CNN_OUT1;
            r_best_idx <= '0;
            r_second   <= MOST_NEG;
            r_idx      <= 3'd1;
          end
        end
        ST_SCAN: begin
          // strict compares keep the lower index on ties
          if (w_x > r_best) begin
            r_second   <= r_best;
            r_best     <= w_x;
            r_best_idx <= r_idx;
          end else if (w_x > r_second) begin
            r_second <= w_x;
          end
          r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_result_valid  <= 1'b0;
      r_result_class  <= '0;
      r_result_margin <= '0;
      r_confident     <= 1'b0;
      r_stable        <= 1'b0;
      r_cnt           <= '0;
      r_last_class    <= INVALID_CLASS;
    end else begin
      r_result_valid <= 1'b0;
      if (r_state == ST_DECIDE) begin
        r_result_valid  <= 1'b1;
        r_result_class  <= r_best_idx;
        r_result_margin <= w_margin;
        r_confident     <= w_confident;
        if (CLEAR) begin
          r_cnt        <= '0;
          r_last_class <= INVALID_CLASS;
          r_stable     <= 1'b0;
        end else begin
          r_cnt        <= w_cnt_nxt;
          r_last_class <= w_last_nxt;
          r_stable     <= (w_cnt_nxt >= CNT_MAX);
        end
      end else if (CLEAR) begin
        r_cnt        <= '0;
        r_last_class <= INVALID_CLASS;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                  r_overrun <= 1'b0;
    else if (CLEAR)                             r_overrun <= 1'b0;
    else if (CNN_VALID && (r_state != ST_IDLE)) r_overrun <= 1'b1;
  end

  assign BUSY          = (r_state != ST_IDLE);
  assign RESULT_VALID  = r_result_valid;
  assign RESULT_CLASS  = r_result_class;
  assign RESULT_MARGIN = r_result_margin;
  assign CONFIDENT     = r_confident;
  assign STABLE        = r_stable;
  assign OVERRUN       = r_overrun;

endmodule

// File: tb/tb_cnn_argmax_vote.sv
// tb/tb_cnn_argmax_vote.sv - self-checking bench for cnn_argmax_vote against an array-based reference model
module tb_cnn_argmax_vote;

  localparam int DW = 24;
  localparam int SC = 3;

  logic                 CLK = 1'b0;
  logic                 RSTn = 1'b0;
  logic                 CNN_VALID = 1'b0;
  logic                 CLEAR = 1'b0;
  logic signed [DW-1:0] CNN_OUT1 = '0, CNN_OUT2 = '0, CNN_OUT3 = '0;
  logic signed [DW-1:0] CNN_OUT4 = '0, CNN_OUT5 = '0, CNN_OUT6 = '0;
  logic        [DW:0]   MARGIN_TH = '0;
  logic                 BUSY, RESULT_VALID, CONFIDENT, STABLE, OVERRUN;
  logic        [2:0]    RESULT_CLASS;
  logic        [DW:0]   RESULT_MARGIN;

  cnn_argmax_vote #(.DW(DW), .STABLE_CNT(SC)) dut (
    .CLK(CLK), .RSTn(RSTn), .CNN_VALID(CNN_VALID),
    .CNN_OUT1(CNN_OUT1), .CNN_OUT2(CNN_OUT2), .CNN_OUT3(CNN_OUT3),
    .CNN_OUT4(CNN_OUT4), .CNN_OUT5(CNN_OUT5), .CNN_OUT6(CNN_OUT6),
    .MARGIN_TH(MARGIN_TH), .CLEAR(CLEAR), .BUSY(BUSY),
    .RESULT_VALID(RESULT_VALID), .RESULT_CLASS(RESULT_CLASS),
    .RESULT_MARGIN(RESULT_MARGIN), .CONFIDENT(CONFIDENT),
    .STABLE(STABLE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int sc [6];
  int m_cnt  = 0;
  int m_last = 7;

  task automatic drive_scores(input int th);
    CNN_OUT1  = DW'(sc[0]);
    CNN_OUT2  = DW'(sc[1]);
    CNN_OUT3  = DW'(sc[2]);
    CNN_OUT4  = DW'(sc[3]);
    CNN_OUT5  = DW'(sc[4]);
    CNN_OUT6  = DW'(sc[5]);
    MARGIN_TH = (DW+1)'(th);
  endtask

  task automatic set_sc(input int a, b, c, d, e, f);
    sc[0] = a; sc[1] = b; sc[2] = c; sc[3] = d; sc[4] = e; sc[5] = f;
  endtask

  function automatic void ref_result(output int cls, output int mrg);
    int bi = 0;
    int second = -(1 << (DW-1));
    for (int i = 1; i < 6; i++) if (sc[i] > sc[bi]) bi = i;
    for (int i = 0; i < 6; i++) if (i != bi && sc[i] > second) second = sc[i];
    cls = bi;
    mrg = sc[bi] - second;
  endfunction

  function automatic bit ref_vote(input int cls, input bit conf);
    if (!conf)             m_cnt = 0;
    else if (cls == m_last) m_cnt = (m_cnt + 1 > SC) ? SC : m_cnt + 1;
    else begin m_cnt = 1; m_last = cls; end
    return (m_cnt >= SC);
  endfunction

  task automatic collect_frame(input int th, output int lat, output int cls, output int mrg,
                               output bit conf, output bit stb, output bit rv_after);
    @(negedge CLK); drive_scores(th); CNN_VALID = 1'b1;
    @(negedge CLK); CNN_VALID = 1'b0; lat = 1;
    while (RESULT_VALID !== 1'b1 && lat < 20) begin @(negedge CLK); lat++; end
    cls = int'(RESULT_CLASS); mrg = int'(RESULT_MARGIN); conf = CONFIDENT; stb = STABLE;
    @(negedge CLK); rv_after = RESULT_VALID;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({BUSY, RESULT_VALID, RESULT_CLASS, RESULT_MARGIN, CONFIDENT, STABLE, OVERRUN} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0",
        {BUSY, RESULT_VALID, RESULT_CLASS, RESULT_MARGIN, CONFIDENT, STABLE, OVERRUN});
    end
    RSTn = 1'b1;
  endtask

  task automatic test_basic();
    int lat, cls, mrg; bit conf, stb, rva;
    set_sc(5, -3, 100, 20, 7, 0);
    collect_frame(10, lat, cls, mrg, conf, stb, rva);
    void'(ref_vote(2, 1'b1));
    n_checks++; if (lat !== 7)   begin n_fail++; $display("FAIL basic_latency: got %0d required 7", lat); end
    n_checks++; if (cls !== 2)   begin n_fail++; $display("FAIL basic_class: got %0d required 2", cls); end
    n_checks++; if (mrg !== 80)  begin n_fail++; $display("FAIL basic_margin: got %0d required 80", mrg); end
    n_checks++; if (conf !== 1'b1) begin n_fail++; $display("FAIL basic_confident: got %0d required 1", conf); end
    n_checks++; if (stb !== 1'b0)  begin n_fail++; $display("FAIL basic_stable: got %0d required 0", stb); end
    n_checks++; if (rva !== 1'b0)  begin n_fail++; $display("FAIL basic_pulse_width: got %0d required 0", rva); end
  endtask

  task automatic test_tie_negative();
    int lat, cls, mrg; bit conf, stb, rva;
    set_sc(-50, -10, -10, -60, -70, -80);
    collect_frame(1, lat, cls, mrg, conf, stb, rva);
    void'(ref_vote(1, 1'b0));
    n_checks++; if (cls !== 1)     begin n_fail++; $display("FAIL tie_class: got %0d required 1", cls); end
    n_checks++; if (mrg !== 0)     begin n_fail++; $display("FAIL tie_margin: got %0d required 0", mrg); end
    n_checks++; if (conf !== 1'b0) begin n_fail++; $display("FAIL tie_confident: got %0d required 0", conf); end
    n_checks++; if (stb !== 1'b0)  begin n_fail++; $display("FAIL tie_stable: got %0d required 0", stb); end
  endtask

  task automatic test_stability();
    int lat, cls, mrg; bit conf, stb, rva;
    bit exp_stb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int f = 0; f < 4; f++) begin
      if (f < 3) set_sc(0, 10, 20, -5, 50, 1);
      else       set_sc(0, 60, 20, -5, 10, 1);
      collect_frame(10, lat, cls, mrg, conf, stb, rva);
      void'(ref_vote(cls, conf));
      n_checks++;
      if (stb !== exp_stb[f] || cls !== ((f < 3) ? 4 : 1)) begin
        n_fail++; $display("FAIL stability_frame%0d: got stable=%0d class=%0d required stable=%0d class=%0d",
                           f, stb, cls, exp_stb[f], (f < 3) ? 4 : 1);
      end
    end
  endtask

  task automatic test_overrun();
    int n_rv = 0, cls = -1, mrg = -1, ref_cls, ref_mrg; bit stb = 1'b0, exp_stb;
    set_sc(5, -3, 100, 20, 7, 0);
    @(negedge CLK); drive_scores(10); CNN_VALID = 1'b1;
    @(negedge CLK); CNN_VALID = 1'b0;
    for (int c = 1; c < 25; c++) begin
      if (c == 3) begin
        CNN_VALID = 1'b1; CNN_OUT1 = 24'sd1000; CNN_OUT4 = 24'sd2000;
      end
      if (c == 4) CNN_VALID = 1'b0;
      if (RESULT_VALID === 1'b1) begin
        n_rv++; cls = int'(RESULT_CLASS); mrg = int'(RESULT_MARGIN); stb = STABLE;
      end
      @(negedge CLK);
    end
    ref_result(ref_cls, ref_mrg);
    exp_stb = ref_vote(ref_cls, ref_mrg >= 10);
    n_checks++; if (n_rv !== 1) begin n_fail++; $display("FAIL overrun_result_count: got %0d required 1", n_rv); end
    n_checks++;
    if (cls !== ref_cls || mrg !== ref_mrg || stb !== exp_stb) begin
      n_fail++; $display("FAIL overrun_frame_intact: got class=%0d margin=%0d stable=%0d required %0d %0d %0d",
                         cls, mrg, stb, ref_cls, ref_mrg, exp_stb);
    end
    n_checks++; if (OVERRUN !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %0d required 1", OVERRUN); end
    CLEAR = 1'b1; @(negedge CLK); CLEAR = 1'b0;
    m_cnt = 0; m_last = 7;
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %0d required 0", OVERRUN); end
  endtask

  task automatic test_extremes();
    int lat, cls, mrg; bit conf, stb, rva;
    set_sc(8388607, -8388608, -8388608, -8388608, -8388608, -8388608);
    collect_frame(16777215, lat, cls, mrg, conf, stb, rva);
    void'(ref_vote(0, 1'b1));
    n_checks++; if (cls !== 0)        begin n_fail++; $display("FAIL extreme_class: got %0d required 0", cls); end
    n_checks++; if (mrg !== 16777215) begin n_fail++; $display("FAIL extreme_margin: got %0d required 16777215", mrg); end
    n_checks++; if (conf !== 1'b1)    begin n_fail++; $display("FAIL extreme_confident: got %0d required 1", conf); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, cls, mrg; bit conf, stb, rva, seen = 1'b0;
    set_sc(5, -3, 100, 20, 7, 0);
    @(negedge CLK); drive_scores(10); CNN_VALID = 1'b1;
    @(negedge CLK); CNN_VALID = 1'b0;
    @(negedge CLK); @(negedge CLK);
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL midscan_busy: got %0d required 1", BUSY); end
    RSTn = 1'b0; #1;
    n_checks++;
    if ({BUSY, RESULT_VALID, RESULT_CLASS, RESULT_MARGIN, CONFIDENT, STABLE, OVERRUN} !== '0) begin
      n_fail++; $display("FAIL midscan_reset_outputs: got %h required 0",
        {BUSY, RESULT_VALID, RESULT_CLASS, RESULT_MARGIN, CONFIDENT, STABLE, OVERRUN});
    end
    @(negedge CLK); RSTn = 1'b1;
    m_cnt = 0; m_last = 7;
    repeat (15) begin @(negedge CLK); if (RESULT_VALID === 1'b1) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midscan_no_result: got %0d required 0", seen); end
    collect_frame(10, lat, cls, mrg, conf, stb, rva);
    void'(ref_vote(2, 1'b1));
    n_checks++;
    if (lat !== 7 || cls !== 2 || mrg !== 80 || stb !== 1'b0) begin
      n_fail++; $display("FAIL midscan_next_frame: got lat=%0d class=%0d margin=%0d stable=%0d required 7 2 80 0",
                         lat, cls, mrg, stb);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ref_cls, ref_mrg; bit exp_stb;
    set_sc(5, -3, 100, 20, 7, 0);
    @(negedge CLK); drive_scores(10); CNN_VALID = 1'b1;
    @(negedge CLK); CNN_VALID = 1'b0; lat = 1;
    while (RESULT_VALID !== 1'b1 && lat < 20) begin @(negedge CLK); lat++; end
    ref_result(ref_cls, ref_mrg);
    exp_stb = ref_vote(ref_cls, ref_mrg >= 10);
    n_checks++;
    if (RESULT_CLASS !== 3'(ref_cls) || STABLE !== exp_stb) begin
      n_fail++; $display("FAIL b2b_first: got class=%0d stable=%0d required %0d %0d", RESULT_CLASS, STABLE, ref_cls, exp_stb);
    end
    set_sc(0, 10, 20, -5, 50, 1);
    drive_scores(10); CNN_VALID = 1'b1;
    @(negedge CLK); CNN_VALID = 1'b0; lat = 1;
    while (RESULT_VALID !== 1'b1 && lat < 20) begin @(negedge CLK); lat++; end
    ref_result(ref_cls, ref_mrg);
    exp_stb = ref_vote(ref_cls, ref_mrg >= 10);
    n_checks++;
    if (lat !== 7 || RESULT_CLASS !== 3'(ref_cls) || int'(RESULT_MARGIN) !== ref_mrg || STABLE !== exp_stb) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d class=%0d margin=%0d stable=%0d required 7 %0d %0d %0d",
                         lat, RESULT_CLASS, RESULT_MARGIN, STABLE, ref_cls, ref_mrg, exp_stb);
    end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %0d required 0", OVERRUN); end
  endtask

  task automatic test_clear_decide();
    int lat, cls, mrg; bit conf, stb, rva, exp_stb;
    set_sc(0, 10, 20, -5, 50, 1);
    for (int f = 0; f < 3; f++) begin
      collect_frame(10, lat, cls, mrg, conf, stb, rva);
      exp_stb = ref_vote(4, 1'b1);
      n_checks++; if (stb !== exp_stb) begin n_fail++; $display("FAIL clrdec_build%0d: got %0d required %0d", f, stb, exp_stb); end
    end
    @(negedge CLK); drive_scores(10); CNN_VALID = 1'b1;
    @(negedge CLK); CNN_VALID = 1'b0; lat = 1;
    while (lat < 6) begin @(negedge CLK); lat++; end
    CLEAR = 1'b1; @(negedge CLK); CLEAR = 1'b0;
    m_cnt = 0; m_last = 7;
    n_checks++;
    if (RESULT_VALID !== 1'b1 || RESULT_CLASS !== 3'd4 || CONFIDENT !== 1'b1 || STABLE !== 1'b0) begin
      n_fail++; $display("FAIL clrdec_result: got valid=%0d class=%0d conf=%0d stable=%0d required 1 4 1 0",
                         RESULT_VALID, RESULT_CLASS, CONFIDENT, STABLE);
    end
    collect_frame(10, lat, cls, mrg, conf, stb, rva);
    exp_stb = ref_vote(4, 1'b1);
    n_checks++; if (stb !== exp_stb) begin n_fail++; $display("FAIL clrdec_after: got %0d required %0d", stb, exp_stb); end
  endtask

  task automatic test_random();
    int lat, cls, mrg, ref_cls, ref_mrg, w, th; bit conf, stb, rva, exp_conf, exp_stb;
    for (int f = 0; f < 60; f++) begin
      w = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 5));
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 9) == 0) sc[i] = int'($urandom_range(0, 16777215)) - 8388608;
        else                          sc[i] = int'($urandom_range(0, 2000)) - 1000;
      end
      if ($urandom_range(0, 3) != 0) sc[w] = sc[w] + 1500;
      if ($urandom_range(0, 7) == 0) sc[(w + 1) % 6] = sc[w];
      th = int'($urandom_range(0, 1200));
      collect_frame(th, lat, cls, mrg, conf, stb, rva);
      ref_result(ref_cls, ref_mrg);
      exp_conf = (ref_mrg >= th);
      exp_stb  = ref_vote(ref_cls, exp_conf);
      n_checks++;
      if (lat !== 7 || cls !== ref_cls || mrg !== ref_mrg || conf !== exp_conf || stb !== exp_stb || rva !== 1'b0) begin
        n_fail++; $display("FAIL random_frame%0d: got lat=%0d class=%0d margin=%0d conf=%0d stable=%0d rv_after=%0d required 7 %0d %0d %0d %0d 0",
                           f, lat, cls, mrg, conf, stb, rva, ref_cls, ref_mrg, exp_conf, exp_stb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_negative();
    test_stability();
    test_overrun();
    test_extremes();
    test_reset_mid_scan();
    test_back_to_back();
    test_clear_decide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
